// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the Register_file write port between two writeback
// requesters, with a pending-write scoreboard and RAW stall. REGFILE_FWD_EN adds forwarding.
module regfile_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_valid,
    input  logic [ADDR_W-1:0]      a_dest,
    input  logic [DATA_W-1:0]      a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [ADDR_W-1:0]      b_dest,
    input  logic [DATA_W-1:0]      b_data,
    output logic                   b_ready,
    input  logic                   alloc_valid,
    input  logic [ADDR_W-1:0]      alloc_dest,
    input  logic [ADDR_W-1:0]      srcreg1,
    input  logic [ADDR_W-1:0]      srcreg2,
    output logic                   stall,
    output logic                   fwd1_hit,
    output logic                   fwd2_hit,
    output logic [DATA_W-1:0]      fwd_data,
    output logic                   write,
    output logic [ADDR_W-1:0]      destreg,
    output logic [DATA_W-1:0]      wrtData,
    output logic [2**ADDR_W-1:0]   busy_mask,
    output logic                   alloc_err
);

    localparam int NREG = 2**ADDR_W;

    localparam logic [0:0] SIDE_A = 1'b0;
    localparam logic [0:0] SIDE_B = 1'b1;

    logic [0:0]      rr_last;
    logic            grant_a;
    logic            grant_b;
    logic [NREG-1:0] busy_next;
    logic            alloc_conflict;

    // Handshake: a request transfers on any cycle where x_valid && x_ready; ready is a
    // pure function of both valids and rr_last, and a requester must hold its request until accepted.
    assign grant_a = ~reset & a_valid & (~b_valid | (rr_last == SIDE_B));
    assign grant_b = ~reset & b_valid & ~grant_a;
    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write   <= 1'b0;
            destreg <= '0;
            wrtData <= '0;
            rr_last <= SIDE_B;
        end else if (grant_a) begin
            write   <= 1'b1;
            destreg <= a_dest;
            wrtData <= a_data;
            rr_last <= SIDE_A;
        end else if (grant_b) begin
            write   <= 1'b1;
            destreg <= b_dest;
            wrtData <= b_data;
            rr_last <= SIDE_B;
        end else begin
            write   <= 1'b0;
        end
    end

    // A new allocation outranks the retiring write to the same register.
    always_comb begin
        busy_next = busy_mask;
        for (int r = 0; r < NREG; r++) begin
            if (alloc_valid && (alloc_dest == ADDR_W'(r))) begin
                busy_next[r] = 1'b1;
            end else if (write && (destreg == ADDR_W'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    assign alloc_conflict = alloc_valid & busy_mask[alloc_dest] &
                            ~(write & (destreg == alloc_dest));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_mask <= '0;
            alloc_err <= 1'b0;
        end else begin
            busy_mask <= busy_next;
            if (alloc_conflict) begin
                alloc_err <= 1'b1;
            end
        end
    end

`ifdef REGFILE_FWD_EN
    assign fwd1_hit = write & busy_mask[srcreg1] & (destreg == srcreg1);
    assign fwd2_hit = write & busy_mask[srcreg2] & (destreg == srcreg2);
    assign fwd_data = wrtData;
`else
    assign fwd1_hit = 1'b0;
    assign fwd2_hit = 1'b0;
    assign fwd_data = '0;
`endif

    assign stall = (busy_mask[srcreg1] & ~fwd1_hit) | (busy_mask[srcreg2] & ~fwd2_hit);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of arbitration, scoreboard and write port.
module tb_regfile_wb_arbiter;

    logic       clk;
    logic       reset;
    logic       a_valid, b_valid, alloc_valid;
    logic [2:0] a_dest, b_dest, alloc_dest, srcreg1, srcreg2;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, stall, fwd1_hit, fwd2_hit, write, alloc_err;
    logic [7:0] fwd_data, wrtData, busy_mask;
    logic [2:0] destreg;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit         m_write;
    bit [2:0]   m_dest;
    bit [7:0]   m_data;
    bit         m_busy [8];
    bit         m_err;
    bit         m_last_b;
    bit         m_ga, m_gb;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
        .srcreg1(srcreg1), .srcreg2(srcreg2),
        .stall(stall), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
        .write(write), .destreg(destreg), .wrtData(wrtData),
        .busy_mask(busy_mask), .alloc_err(alloc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_write  = 1'b0;
        m_dest   = '0;
        m_data   = '0;
        m_err    = 1'b0;
        m_last_b = 1'b1;
        for (int r = 0; r < 8; r++) m_busy[r] = 1'b0;
    endtask

    task automatic clear_inputs();
        a_valid = 0; b_valid = 0; alloc_valid = 0;
        a_dest = 0; b_dest = 0; alloc_dest = 0;
        a_data = 0; b_data = 0; srcreg1 = 0; srcreg2 = 0;
    endtask

    // Called at a negedge: reset asserts, outputs must drop without a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_write", 32'(write), 32'd0);
        check_eq("rst_busy", 32'(busy_mask), 32'd0);
        check_eq("rst_err", 32'(alloc_err), 32'd0);
        check_eq("rst_a_ready", 32'(a_ready), 32'd0);
        check_eq("rst_b_ready", 32'(b_ready), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Inputs are already set (just after a negedge). Check, advance model, wait next negedge.
    task automatic cycle();
        bit ga, gb, h1, h2, st;
        bit nb [8];
        logic [7:0] pk;
        #1;
        ga = a_valid && (!b_valid || m_last_b);
        gb = b_valid && !ga;
`ifdef REGFILE_FWD_EN
        h1 = m_write && m_busy[srcreg1] && (m_dest == srcreg1);
        h2 = m_write && m_busy[srcreg2] && (m_dest == srcreg2);
`else
        h1 = 1'b0;
        h2 = 1'b0;
`endif
        st = (m_busy[srcreg1] && !h1) || (m_busy[srcreg2] && !h2);
        for (int r = 0; r < 8; r++) pk[r] = m_busy[r];
        check_eq("a_ready", 32'(a_ready), 32'(ga));
        check_eq("b_ready", 32'(b_ready), 32'(gb));
        check_eq("stall", 32'(stall), 32'(st));
        check_eq("fwd1_hit", 32'(fwd1_hit), 32'(h1));
        check_eq("fwd2_hit", 32'(fwd2_hit), 32'(h2));
`ifdef REGFILE_FWD_EN
        check_eq("fwd_data", 32'(fwd_data), 32'(m_data));
`else
        check_eq("fwd_data", 32'(fwd_data), 32'd0);
`endif
        check_eq("write", 32'(write), 32'(m_write));
        check_eq("destreg", 32'(destreg), 32'(m_dest));
        check_eq("wrtData", 32'(wrtData), 32'(m_data));
        check_eq("busy_mask", 32'(busy_mask), 32'(pk));
        check_eq("alloc_err", 32'(alloc_err), 32'(m_err));
        nb = m_busy;
        for (int r = 0; r < 8; r++) begin
            if (alloc_valid && alloc_dest == 3'(r)) nb[r] = 1'b1;
            else if (m_write && m_dest == 3'(r)) nb[r] = 1'b0;
        end
        if (alloc_valid && m_busy[alloc_dest] && !(m_write && m_dest == alloc_dest)) m_err = 1'b1;
        m_busy  = nb;
        m_write = ga || gb;
        if (ga) begin
            m_dest = a_dest; m_data = a_data; m_last_b = 1'b0;
        end else if (gb) begin
            m_dest = b_dest; m_data = b_data; m_last_b = 1'b1;
        end
        m_ga = ga;
        m_gb = gb;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        model_reset();
        // reset held with a request pending
        a_valid = 1; a_dest = 3'd1; a_data = 8'd5;
        @(negedge clk);
        do_reset();
        #1;
        check_eq("release_a_ready", 32'(a_ready), 32'd1);
        cycle();

        // alloc r1 then write 42 to r1
        clear_inputs();
        alloc_valid = 1; alloc_dest = 3'd1;
        cycle();
        clear_inputs();
        a_valid = 1; a_dest = 3'd1; a_data = 8'd42;
        cycle();
        clear_inputs();
        check_eq("t2_write", 32'(write), 32'd1);
        check_eq("t2_destreg", 32'(destreg), 32'd1);
        check_eq("t2_data", 32'(wrtData), 32'd42);
        check_eq("t2_busy1_set", 32'(busy_mask[1]), 32'd1);
        cycle();
        check_eq("t2_busy1_clr", 32'(busy_mask[1]), 32'd0);

        // both requesters valid for three cycles: A, B, A
        clear_inputs();
        do_reset();
        a_valid = 1; a_dest = 3'd2; a_data = 8'd99;
        b_valid = 1; b_dest = 3'd3; b_data = 8'd7;
        cycle();
        check_eq("t3_w1", 32'(wrtData), 32'd99);
        cycle();
        check_eq("t3_w2", 32'(wrtData), 32'd7);
        check_eq("t3_d2", 32'(destreg), 32'd3);
        cycle();
        check_eq("t3_w3", 32'(wrtData), 32'd99);
        check_eq("t3_wr3", 32'(write), 32'd1);

        // RAW stall and forwarding on r2
        clear_inputs();
        alloc_valid = 1; alloc_dest = 3'd2;
        cycle();
        clear_inputs();
        srcreg1 = 3'd2; a_valid = 1; a_dest = 3'd2; a_data = 8'd99;
        #1;
        check_eq("t4_stall_busy", 32'(stall), 32'd1);
        cycle();
        clear_inputs();
        srcreg1 = 3'd2;
        #1;
`ifdef REGFILE_FWD_EN
        check_eq("t4_fwd_hit", 32'(fwd1_hit), 32'd1);
        check_eq("t4_fwd_data", 32'(fwd_data), 32'd99);
        check_eq("t4_fwd_stall", 32'(stall), 32'd0);
`else
        check_eq("t4_nofwd_hit", 32'(fwd1_hit), 32'd0);
        check_eq("t4_nofwd_stall", 32'(stall), 32'd1);
`endif
        cycle();

        // double alloc sets sticky error; alloc+retire same reg keeps busy
        clear_inputs();
        alloc_valid = 1; alloc_dest = 3'd4;
        cycle();
        check_eq("t5_err_before", 32'(alloc_err), 32'd0);
        cycle();
        check_eq("t5_err_set", 32'(alloc_err), 32'd1);
        clear_inputs();
        a_valid = 1; a_dest = 3'd5; a_data = 8'd3;
        cycle();
        clear_inputs();
        alloc_valid = 1; alloc_dest = 3'd5;
        cycle();
        clear_inputs();
        check_eq("t5_busy5", 32'(busy_mask[5]), 32'd1);
        check_eq("t5_err_sticky", 32'(alloc_err), 32'd1);
        cycle();

        // reset while a write is pending
        a_valid = 1; a_dest = 3'd6; a_data = 8'd1;
        cycle();
        clear_inputs();
        check_eq("t6_write_pending", 32'(write), 32'd1);
        do_reset();

        // randomized traffic; requesters hold until accepted
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                clear_inputs();
                do_reset();
            end
            if (!a_valid && $urandom_range(0, 1) == 1) begin
                a_valid = 1; a_dest = 3'($urandom_range(0, 7)); a_data = 8'($urandom_range(0, 255));
            end
            if (!b_valid && $urandom_range(0, 1) == 1) begin
                b_valid = 1; b_dest = 3'($urandom_range(0, 7)); b_data = 8'($urandom_range(0, 255));
            end
            alloc_valid = ($urandom_range(0, 3) == 0);
            alloc_dest  = 3'($urandom_range(0, 7));
            srcreg1     = 3'($urandom_range(0, 7));
            srcreg2     = 3'($urandom_range(0, 7));
            cycle();
            if (m_ga) a_valid = 0;
            if (m_gb) b_valid = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
